// File: rtl/voice_pkg.sv
// voice_pkg: types and constants shared across the voice-change chain.
package voice_pkg;

    localparam int SAMPLE_W          = 16;
    localparam int RAMP_LOG2_DEFAULT = 6;

    typedef enum logic [1:0] {
        XF_DRY,
        XF_RAMP_UP,
        XF_WET,
        XF_RAMP_DN
    } xf_state_e;

endpackage

// File: rtl/xfade_gain_ctr.sv
// xfade_gain_ctr: bounded up/down crossfade gain counter (0..2^RAMP_LOG2).
// It steps once per strobe toward the requested path. It also decodes the
// crossfade state from the gain and the latched request, and drives busy.
module xfade_gain_ctr
    import voice_pkg::*;
#(
    parameter int RAMP_LOG2 = RAMP_LOG2_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               strobe_i,
    input  logic               dir_i,
    output logic [RAMP_LOG2:0] gain_o,
    output logic               busy_o
);

    localparam int             G_W  = RAMP_LOG2 + 1;
    localparam logic [G_W-1:0] GMAX = G_W'(1) << RAMP_LOG2;

    logic [G_W-1:0] gain_q, gain_d;
    logic           req_q, req_d;
    xf_state_e      state_q, state_d;

    // Step the gain on a strobe, latch the request and decode the next state.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no latch can be inferred.
        gain_d  = gain_q;
        req_d   = req_q;
        state_d = state_q;
        if (strobe_i) begin
            req_d = dir_i;
            if (dir_i && (gain_q != GMAX)) begin
                gain_d = gain_q + G_W'(1);
            end else if (!dir_i && (gain_q != '0)) begin
                gain_d = gain_q - G_W'(1);
            end
        end
        if (req_d) begin
            state_d = (gain_d == GMAX) ? XF_WET : XF_RAMP_UP;
        end else begin
            state_d = (gain_d == '0) ? XF_DRY : XF_RAMP_DN;
        end
    end

    // Gain, request and state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gain_q  <= '0;
            req_q   <= 1'b0;
            state_q <= XF_DRY;
        end else begin
            // NOTE: non-blocking assignments make every register sample pre-edge values.
            gain_q  <= gain_d;
            req_q   <= req_d;
            state_q <= state_d;
        end
    end

    assign gain_o = gain_q;
    assign busy_o = (state_q == XF_RAMP_UP) || (state_q == XF_RAMP_DN);

endmodule

// File: rtl/voice_xfade.sv
// voice_xfade: click-free linear crossfade between the dry and wet sample paths.
// Stage 1 weights both paths by the gain. Stage 2 sums the products and
// rescales the result.
// Optional macro VOICE_XFADE_ROUND_EN: round half up before the rescale
// (default: arithmetic-shift truncation toward minus infinity).
module voice_xfade
    import voice_pkg::*;
#(
    parameter int RAMP_LOG2 = RAMP_LOG2_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sample,
    input  logic [SAMPLE_W-1:0] dry_in,
    input  logic [SAMPLE_W-1:0] wet_in,
    input  logic                change_en,
    output logic [SAMPLE_W-1:0] mix_out,
    output logic                out_valid,
    output logic                busy
);

    localparam int             G_W  = RAMP_LOG2 + 1;
    localparam int             S_W  = SAMPLE_W + RAMP_LOG2 + 1;
    localparam logic [G_W-1:0] GMAX = G_W'(1) << RAMP_LOG2;
`ifdef VOICE_XFADE_ROUND_EN
    localparam logic signed [S_W-1:0] RND = S_W'(1) << (RAMP_LOG2 - 1);
`else
    localparam logic signed [S_W-1:0] RND = '0;
`endif

    logic [G_W-1:0]        gain;
    logic signed [S_W-1:0] p_w_q, p_w_d, p_d_q, p_d_d, sum;
    logic                  vld1_q, out_valid_q;
    logic [SAMPLE_W-1:0]   mix_q, mix_d;

    xfade_gain_ctr #(
        .RAMP_LOG2 (RAMP_LOG2)
    ) u_gain_ctr (
        .clk      (clk),
        .rst_n    (reset),
        .strobe_i (sample),
        .dir_i    (change_en),
        .gain_o   (gain),
        .busy_o   (busy)
    );

    // Stage 1: weight both paths with the gain in effect before this strobe.
    always_comb begin
        p_w_d = p_w_q;
        p_d_d = p_d_q;
        if (sample) begin
            p_w_d = S_W'(signed'(wet_in)) * signed'(S_W'(gain));
            p_d_d = S_W'(signed'(dry_in)) * signed'(S_W'(GMAX - gain));
        end
    end

    // Stage 2: convex sum rescaled by GMAX; always in range, so no saturation.
    always_comb begin
        sum   = p_w_q + p_d_q + RND;
        mix_d = vld1_q ? SAMPLE_W'(sum >>> RAMP_LOG2) : mix_q;
    end

    // Pipeline registers; the valid flag travels two edges behind the strobe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            p_w_q       <= '0;
            p_d_q       <= '0;
            vld1_q      <= 1'b0;
            mix_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            p_w_q       <= p_w_d;
            p_d_q       <= p_d_d;
            vld1_q      <= sample;
            mix_q       <= mix_d;
            out_valid_q <= vld1_q;
        end
    end

    assign mix_out   = mix_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_voice_xfade.sv
// tb_voice_xfade: self-checking bench for voice_xfade against an arithmetic
// reference model (weighted average with floor or round-half-up division).
module tb_voice_xfade;

    localparam int RAMP_LOG2 = 6;
    localparam int GMAX      = 1 << RAMP_LOG2;

    logic        clk = 1'b0;
    logic        reset;
    logic        sample;
    logic        change_en;
    logic [15:0] dry_in;
    logic [15:0] wet_in;
    logic [15:0] mix_out;
    logic        out_valid;
    logic        busy;

    int n_assert = 0;
    int n_fail   = 0;
    int g_model  = 0;

    voice_xfade #(
        .RAMP_LOG2 (RAMP_LOG2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .sample    (sample),
        .dry_in    (dry_in),
        .wet_in    (wet_in),
        .change_en (change_en),
        .mix_out   (mix_out),
        .out_valid (out_valid),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Reference: (wet*g + dry*(GMAX-g)) / GMAX, floored (optionally +GMAX/2 first).
    function automatic int model_mix(input int d, input int w, input int g);
        int num;
        int q;
        num = w * g + d * (GMAX - g);
`ifdef VOICE_XFADE_ROUND_EN
        num = num + GMAX / 2;
`endif
        q = num / GMAX;
        if (((num % GMAX) != 0) && (num < 0)) q = q - 1;
        return q;
    endfunction

    function automatic bit model_busy(input bit en, input int g);
        return en ? (g < GMAX) : (g > 0);
    endfunction

    task automatic model_step(input bit en);
        if (en && g_model < GMAX) g_model++;
        else if (!en && g_model > 0) g_model--;
    endtask

    // One strobe: drive inputs, predict result and busy, end one negedge later.
    task automatic drive_strobe(input int d, input int w, input bit en,
                                output int exp_mix, output bit exp_busy);
        @(negedge clk);
        dry_in    = 16'(d);
        wet_in    = 16'(w);
        change_en = en;
        sample    = 1'b1;
        exp_mix   = model_mix(d, w, g_model);
        model_step(en);
        exp_busy  = model_busy(en, g_model);
        @(negedge clk);
        sample = 1'b0;
    endtask

    task automatic move_gain_to(input int target);
        int e;
        bit b;
        while (g_model != target) drive_strobe(0, 0, (g_model < target), e, b);
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset;
        int e;
        bit b;
        reset = 1'b0; sample = 1'b0; change_en = 1'b0;
        dry_in = 16'd1000; wet_in = 16'(-2000);
        repeat (2) @(negedge clk);
        n_assert++; if (mix_out !== 16'd0) begin n_fail++; $display("FAIL reset_mix: got %0d expected 0", $signed(mix_out)); end
        n_assert++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        n_assert++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        reset = 1'b1;
        g_model = 0;
        for (int i = 0; i < 3; i++) begin
            drive_strobe(1000, -2000, 1'b0, e, b);
            n_assert++; if (busy !== b) begin n_fail++; $display("FAIL dry_busy: got %b expected %b", busy, b); end
            n_assert++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL dry_valid_early: got %b expected 0", out_valid); end
            @(negedge clk);
            n_assert++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL dry_valid: got %b expected 1", out_valid); end
            n_assert++; if (mix_out !== 16'(e)) begin n_fail++; $display("FAIL dry_mix_model: got %0d expected %0d", $signed(mix_out), e); end
            n_assert++; if (mix_out !== 16'd1000) begin n_fail++; $display("FAIL dry_mix: got %0d expected 1000", $signed(mix_out)); end
            @(negedge clk);
            n_assert++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL dry_valid_len: got %b expected 0", out_valid); end
        end
    endtask

    task automatic test_ramp_up;
        int e;
        int gb;
        bit b;
        for (int i = 1; i <= 70; i++) begin
            gb = g_model;
            drive_strobe(1000, -2000, 1'b1, e, b);
            n_assert++; if (busy !== b) begin n_fail++; $display("FAIL ramp_busy[%0d]: got %b expected %b", i, busy, b); end
            @(negedge clk);
            n_assert++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL ramp_valid[%0d]: got %b expected 1", i, out_valid); end
            n_assert++; if (mix_out !== 16'(e)) begin n_fail++; $display("FAIL ramp_mix[%0d]: got %0d expected %0d", i, $signed(mix_out), e); end
            if (gb == 32) begin
                n_assert++; if (mix_out !== 16'(-500)) begin n_fail++; $display("FAIL ramp_half: got %0d expected -500", $signed(mix_out)); end
            end
            if (i >= 65) begin
                n_assert++; if (mix_out !== 16'(-2000)) begin n_fail++; $display("FAIL ramp_wet[%0d]: got %0d expected -2000", i, $signed(mix_out)); end
                n_assert++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ramp_wet_busy[%0d]: got %b expected 0", i, busy); end
            end
        end
    endtask

    task automatic test_extremes;
        int e;
        int prev;
        bit b;
        move_gain_to(0);
        prev = 32767;
        for (int i = 0; i <= GMAX; i++) begin
            drive_strobe(32767, -32768, 1'b1, e, b);
            @(negedge clk);
            n_assert++; if (mix_out !== 16'(e)) begin n_fail++; $display("FAIL ext_mix[%0d]: got %0d expected %0d", i, $signed(mix_out), e); end
            n_assert++; if ($signed(mix_out) > prev) begin n_fail++; $display("FAIL ext_monotonic[%0d]: got %0d expected <= %0d", i, $signed(mix_out), prev); end
            if (i == 0) begin
                n_assert++; if (mix_out !== 16'd32767) begin n_fail++; $display("FAIL ext_first: got %0d expected 32767", $signed(mix_out)); end
            end
            if (i == GMAX) begin
                n_assert++; if (mix_out !== 16'h8000) begin n_fail++; $display("FAIL ext_last: got %0d expected -32768", $signed(mix_out)); end
            end
            prev = $signed(mix_out);
        end
    endtask

    // wet = 100*GMAX, dry = 0 makes mix_out = 100*g, exposing the gain directly.
    task automatic test_reversal;
        int e;
        int gexp;
        bit b;
        move_gain_to(0);
        for (int i = 0; i <= 20; i++) begin
            drive_strobe(0, 100 * GMAX, 1'b1, e, b);
            @(negedge clk);
            n_assert++; if (mix_out !== 16'(100 * i)) begin n_fail++; $display("FAIL rev_up[%0d]: got %0d expected %0d", i, $signed(mix_out), 100 * i); end
        end
        for (int i = 0; i <= 22; i++) begin
            gexp = (i <= 21) ? 21 - i : 0;
            drive_strobe(0, 100 * GMAX, 1'b0, e, b);
            n_assert++; if (busy !== b) begin n_fail++; $display("FAIL rev_busy[%0d]: got %b expected %b", i, busy, b); end
            @(negedge clk);
            n_assert++; if (mix_out !== 16'(100 * gexp)) begin n_fail++; $display("FAIL rev_dn[%0d]: got %0d expected %0d", i, $signed(mix_out), 100 * gexp); end
        end
        drive_strobe(1234, 100 * GMAX, 1'b0, e, b);
        n_assert++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rev_dry_busy: got %b expected 0", busy); end
        @(negedge clk);
        n_assert++; if (mix_out !== 16'd1234) begin n_fail++; $display("FAIL rev_dry_mix: got %0d expected 1234", $signed(mix_out)); end
    endtask

    task automatic test_back_to_back;
        int exp_q[10];
        int pulses;
        int d;
        int w;
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (k >= 2) begin
                if (out_valid === 1'b1) pulses++;
                n_assert++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid[%0d]: got %b expected 1", k - 2, out_valid); end
                n_assert++; if (mix_out !== 16'(exp_q[k-2])) begin n_fail++; $display("FAIL b2b_mix[%0d]: got %0d expected %0d", k - 2, $signed(mix_out), exp_q[k-2]); end
            end
            if (k < 10) begin
                d = int'($urandom_range(0, 65535)) - 32768;
                w = int'($urandom_range(0, 65535)) - 32768;
                dry_in = 16'(d); wet_in = 16'(w); change_en = 1'b1; sample = 1'b1;
                exp_q[k] = model_mix(d, w, g_model);
                model_step(1'b1);
            end else begin
                sample = 1'b0;
            end
        end
        @(negedge clk);
        n_assert++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_tail: got %b expected 0", out_valid); end
        n_assert++; if (pulses != 10) begin n_fail++; $display("FAIL b2b_pulses: got %0d expected 10", pulses); end
    endtask

    task automatic test_rounding;
        int e;
        int lit;
        bit b;
`ifdef VOICE_XFADE_ROUND_EN
        lit = 1;
`else
        lit = 0;
`endif
        move_gain_to(GMAX / 2);
        drive_strobe(1, 0, 1'b1, e, b);
        @(negedge clk);
        n_assert++; if (mix_out !== 16'(lit)) begin n_fail++; $display("FAIL round_half: got %0d expected %0d", $signed(mix_out), lit); end
        n_assert++; if (mix_out !== 16'(e)) begin n_fail++; $display("FAIL round_model: got %0d expected %0d", $signed(mix_out), e); end
    endtask

    task automatic test_reset_mid_ramp;
        int e;
        bit b;
        move_gain_to(40);
        drive_strobe(0, 100 * GMAX, 1'b1, e, b);
        #2 reset = 1'b0;
        #1;
        n_assert++; if (mix_out !== 16'd0) begin n_fail++; $display("FAIL rst_mid_mix: got %0d expected 0", $signed(mix_out)); end
        n_assert++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
        n_assert++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid: got %b expected 0", out_valid); end
        @(negedge clk);
        g_model = 0;
        reset = 1'b1;
        @(negedge clk);
        n_assert++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_dropped_valid: got %b expected 0", out_valid); end
        for (int i = 0; i < 3; i++) begin
            drive_strobe(500, 100 * GMAX, 1'b1, e, b);
            n_assert++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rst_restart_busy[%0d]: got %b expected 1", i, busy); end
            @(negedge clk);
            n_assert++; if (mix_out !== 16'(e)) begin n_fail++; $display("FAIL rst_restart_mix[%0d]: got %0d expected %0d", i, $signed(mix_out), e); end
            if (i == 0) begin
                n_assert++; if (mix_out !== 16'd500) begin n_fail++; $display("FAIL rst_restart_g0: got %0d expected 500", $signed(mix_out)); end
            end
        end
    endtask

    // Random data and direction flips; change_en is scrambled between strobes.
    task automatic test_random;
        int e;
        int d;
        int w;
        bit b;
        bit en;
        en = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 23) == 0) en = !en;
            d = int'($urandom_range(0, 65535)) - 32768;
            w = int'($urandom_range(0, 65535)) - 32768;
            drive_strobe(d, w, en, e, b);
            change_en = 1'($urandom_range(0, 1));
            n_assert++; if (busy !== b) begin n_fail++; $display("FAIL rnd_busy[%0d]: got %b expected %b", i, busy, b); end
            @(negedge clk);
            n_assert++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rnd_valid[%0d]: got %b expected 1", i, out_valid); end
            n_assert++; if (mix_out !== 16'(e)) begin n_fail++; $display("FAIL rnd_mix[%0d]: got %0d expected %0d", i, $signed(mix_out), e); end
            @(negedge clk);
            n_assert++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rnd_valid_len[%0d]: got %b expected 0", i, out_valid); end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_ramp_up();
        test_extremes();
        test_reversal();
        test_back_to_back();
        test_rounding();
        test_reset_mid_ramp();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
